// File: rtl/hyperram_arbiter.sv
// Two-port round-robin scheduler for the HyperRAM command port: one fixed-length burst per grant,
// write beats streamed from the owner, read beats routed back to it, idle gap and read timeout between commands.
//
// state | meaning
// IDLE  | waiting for an eligible request
// WRITE | command issued, streaming BURST_LEN write beats
// READ  | command issued, collecting BURST_LEN read beats
// GAP   | CMD_GAP idle cycles before the next grant
module hyperram_arbiter #(
   parameter int ADDR_WIDTH = 22,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 16,
   parameter int CMD_GAP    = 4,
   parameter int RD_TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    init_calib,
   input  logic [1:0]              s_req_valid,
   output logic [1:0]              s_req_ready,
   input  logic [1:0]              s_req_we,
   input  logic [ADDR_WIDTH-1:0]   s_req_addr0,
   input  logic [ADDR_WIDTH-1:0]   s_req_addr1,
   output logic [1:0]              s_wr_ready,
   input  logic [DATA_WIDTH-1:0]   s_wr_data0,
   input  logic [DATA_WIDTH-1:0]   s_wr_data1,
   input  logic [DATA_WIDTH/8-1:0] s_wr_mask0,
   input  logic [DATA_WIDTH/8-1:0] s_wr_mask1,
   output logic [DATA_WIDTH-1:0]   s_rd_data,
   output logic [1:0]              s_rd_valid,
   output logic                    mem_cmd,
   output logic                    mem_cmd_en,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wr_data,
   output logic [DATA_WIDTH/8-1:0] mem_data_mask,
   input  logic [DATA_WIDTH-1:0]   mem_rd_data,
   input  logic                    mem_rd_data_valid,
   output logic                    busy,
   output logic                    err_timeout
);

   localparam int BW = $clog2(BURST_LEN + 1);
   localparam int TW = $clog2(RD_TIMEOUT + 1);
   localparam int GW = $clog2(CMD_GAP + 2);
   localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(RD_TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(CMD_GAP - 1);

   typedef enum logic [1:0] {IDLE, WRITE, READ, GAP} state_t;

   // A zero-length gap skips the GAP state entirely.
   localparam state_t POST = (CMD_GAP == 0) ? IDLE : GAP;

   state_t                state, state_nxt;
   logic                  owner, owner_nxt;
   logic                  last_grant, last_grant_nxt;
   logic                  cmd_q, cmd_nxt;
   logic                  cmd_en_q, cmd_en_nxt;
   logic                  err_q, err_nxt;
   logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
   logic [BW-1:0]         beat_cnt, beat_nxt;
   logic [TW-1:0]         tmo_cnt, tmo_nxt;
   logic [GW-1:0]         gap_cnt, gap_nxt;
   logic [1:0]            elig;
   logic                  sel;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         cmd_q      <= 1'b0;
         cmd_en_q   <= 1'b0;
         err_q      <= 1'b0;
         addr_q     <= '0;
         beat_cnt   <= '0;
         tmo_cnt    <= '0;
         gap_cnt    <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_grant <= last_grant_nxt;
         cmd_q      <= cmd_nxt;
         cmd_en_q   <= cmd_en_nxt;
         err_q      <= err_nxt;
         addr_q     <= addr_nxt;
         beat_cnt   <= beat_nxt;
         tmo_cnt    <= tmo_nxt;
         gap_cnt    <= gap_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_grant_nxt = last_grant;
      cmd_nxt        = 1'b0;
      cmd_en_nxt     = 1'b0;
      err_nxt        = err_q;
      addr_nxt       = addr_q;
      beat_nxt       = beat_cnt;
      tmo_nxt        = tmo_cnt;
      gap_nxt        = gap_cnt;
      s_req_ready    = 2'b00;
      s_wr_ready     = 2'b00;
      s_rd_valid     = 2'b00;
      mem_wr_data    = '0;
      mem_data_mask  = '0;

      elig = s_req_valid & {2{init_calib}};
      sel  = (elig == 2'b11) ? ~last_grant : elig[1];

      case (state)
         IDLE: begin
            if (elig != 2'b00) begin
               s_req_ready[sel] = 1'b1;
               owner_nxt        = sel;
               last_grant_nxt   = sel;
               addr_nxt         = sel ? s_req_addr1 : s_req_addr0;
               cmd_nxt          = s_req_we[sel];
               cmd_en_nxt       = 1'b1;
               beat_nxt         = '0;
               tmo_nxt          = '0;
               state_nxt        = s_req_we[sel] ? WRITE : READ;
            end
         end
         WRITE: begin
            s_wr_ready[owner] = 1'b1;
            mem_wr_data       = owner ? s_wr_data1 : s_wr_data0;
            mem_data_mask     = owner ? s_wr_mask1 : s_wr_mask0;
            if (beat_cnt == BEAT_LAST) begin
               beat_nxt  = '0;
               state_nxt = POST;
            end else begin
               beat_nxt = beat_cnt + 1'b1;
            end
         end
         READ: begin
            s_rd_valid[owner] = mem_rd_data_valid;
            // A beat on the threshold cycle takes priority over the timeout.
            if (mem_rd_data_valid) begin
               tmo_nxt = '0;
               if (beat_cnt == BEAT_LAST) begin
                  beat_nxt  = '0;
                  state_nxt = POST;
               end else begin
                  beat_nxt = beat_cnt + 1'b1;
               end
            end else if (tmo_cnt == TMO_LAST) begin
               err_nxt   = 1'b1;
               tmo_nxt   = '0;
               beat_nxt  = '0;
               state_nxt = POST;
            end else begin
               tmo_nxt = tmo_cnt + 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               gap_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               gap_nxt = gap_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Calibration loss abandons the burst without flagging a timeout.
      if (!init_calib) begin
         state_nxt  = IDLE;
         beat_nxt   = '0;
         tmo_nxt    = '0;
         gap_nxt    = '0;
         cmd_nxt    = 1'b0;
         cmd_en_nxt = 1'b0;
         err_nxt    = err_q;
      end
   end

   assign s_rd_data   = mem_rd_data;
   assign mem_cmd     = cmd_q;
   assign mem_cmd_en  = cmd_en_q;
   assign mem_addr    = addr_q;
   assign busy        = (state != IDLE);
   assign err_timeout = err_q;

endmodule

// File: tb/tb_hyperram_arbiter.sv
// Directed bench for hyperram_arbiter: IDLE arbitration vector table plus hand-written burst,
// arbitration, timeout, calibration-loss and reset sequences with hand-computed expectations.
module tb_hyperram_arbiter;

   localparam int AW = 22;
   localparam int DW = 32;
   localparam int MW = 4;
   localparam int BL = 16;
   localparam int CG = 4;
   localparam int TO = 255;

   logic          clk = 1'b0;
   logic          reset;
   logic          init_calib;
   logic [1:0]    s_req_valid;
   logic [1:0]    s_req_ready;
   logic [1:0]    s_req_we;
   logic [AW-1:0] s_req_addr0;
   logic [AW-1:0] s_req_addr1;
   logic [1:0]    s_wr_ready;
   logic [DW-1:0] s_wr_data0;
   logic [DW-1:0] s_wr_data1;
   logic [MW-1:0] s_wr_mask0;
   logic [MW-1:0] s_wr_mask1;
   logic [DW-1:0] s_rd_data;
   logic [1:0]    s_rd_valid;
   logic          mem_cmd;
   logic          mem_cmd_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wr_data;
   logic [MW-1:0] mem_data_mask;
   logic [DW-1:0] mem_rd_data;
   logic          mem_rd_data_valid;
   logic          busy;
   logic          err_timeout;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hyperram_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .CMD_GAP(CG), .RD_TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset), .init_calib(init_calib),
      .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_we(s_req_we),
      .s_req_addr0(s_req_addr0), .s_req_addr1(s_req_addr1),
      .s_wr_ready(s_wr_ready), .s_wr_data0(s_wr_data0), .s_wr_data1(s_wr_data1),
      .s_wr_mask0(s_wr_mask0), .s_wr_mask1(s_wr_mask1),
      .s_rd_data(s_rd_data), .s_rd_valid(s_rd_valid),
      .mem_cmd(mem_cmd), .mem_cmd_en(mem_cmd_en), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_data_mask(mem_data_mask),
      .mem_rd_data(mem_rd_data), .mem_rd_data_valid(mem_rd_data_valid),
      .busy(busy), .err_timeout(err_timeout)
   );

   typedef struct {
      logic       calib;
      logic [1:0] valid;
      logic [1:0] exp_ready;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   int cnt;
   int early;
   int grants[$];
   int stamps[$];

   initial begin
      reset = 1'b1; init_calib = 1'b0; s_req_valid = 2'b00; s_req_we = 2'b00;
      s_req_addr0 = '0; s_req_addr1 = '0;
      s_wr_data0 = '0; s_wr_data1 = 32'hDEAD_BEEF; s_wr_mask0 = '0; s_wr_mask1 = 4'hF;
      mem_rd_data = '0; mem_rd_data_valid = 1'b0;

      vecs[0] = '{1'b0, 2'b00, 2'b00};
      vecs[1] = '{1'b0, 2'b11, 2'b00};
      vecs[2] = '{1'b0, 2'b01, 2'b00};
      vecs[3] = '{1'b1, 2'b00, 2'b00};
      vecs[4] = '{1'b1, 2'b01, 2'b01};
      vecs[5] = '{1'b1, 2'b10, 2'b10};
      vecs[6] = '{1'b1, 2'b11, 2'b01};

      // reset values
      do_reset();
      #1;
      chk("rst_cmd_en", 64'(mem_cmd_en), 64'(0));
      chk("rst_cmd", 64'(mem_cmd), 64'(0));
      chk("rst_addr", 64'(mem_addr), 64'(0));
      chk("rst_wr_data", 64'(mem_wr_data), 64'(0));
      chk("rst_mask", 64'(mem_data_mask), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_err", 64'(err_timeout), 64'(0));
      chk("rst_wr_ready", 64'(s_wr_ready), 64'(0));

      // IDLE arbitration table; requests drop before the edge so none is accepted
      for (int i = 0; i < 7; i++) begin
         tick();
         init_calib  = vecs[i].calib;
         s_req_valid = vecs[i].valid;
         #1;
         chk($sformatf("vec%0d_ready", i), 64'(s_req_ready), 64'(vecs[i].exp_ready));
         chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(0));
         chk($sformatf("vec%0d_cmd_en", i), 64'(mem_cmd_en), 64'(0));
         #2;
         s_req_valid = 2'b00;
      end

      // single write, port 0
      init_calib = 1'b1;
      do_reset();
      s_req_valid = 2'b01; s_req_we = 2'b01; s_req_addr0 = 22'h000100;
      #1;
      chk("wr_accept_ready", 64'(s_req_ready), 64'(2'b01));
      for (int k = 0; k < BL; k++) begin
         tick();
         s_req_valid = 2'b00;
         s_wr_data0 = 32'(k);
         s_wr_mask0 = 4'(k);
         #1;
         chk("wr_cmd_en", 64'(mem_cmd_en), 64'(k == 0));
         if (k == 0) begin
            chk("wr_cmd", 64'(mem_cmd), 64'(1));
            chk("wr_addr", 64'(mem_addr), 64'(22'h000100));
         end
         chk("wr_ready", 64'(s_wr_ready), 64'(2'b01));
         chk("wr_data", 64'(mem_wr_data), 64'(k));
         chk("wr_mask", 64'(mem_data_mask), 64'(k));
      end
      for (int g = 0; g <= CG; g++) begin
         tick();
         #1;
         chk("wr_gap_busy", 64'(busy), 64'(g < CG));
         chk("wr_gap_ready", 64'(s_wr_ready), 64'(0));
      end

      // single read, port 1, two bubbles
      do_reset();
      s_req_valid = 2'b10; s_req_we = 2'b00; s_req_addr1 = 22'h3FFFF0;
      #1;
      chk("rd_accept_ready", 64'(s_req_ready), 64'(2'b10));
      tick();
      s_req_valid = 2'b00;
      #1;
      chk("rd_cmd_en", 64'(mem_cmd_en), 64'(1));
      chk("rd_cmd", 64'(mem_cmd), 64'(0));
      chk("rd_addr", 64'(mem_addr), 64'(22'h3FFFF0));
      cnt = 0;
      for (int j = 0; j < BL + 2; j++) begin
         tick();
         mem_rd_data_valid = (j != 5 && j != 11);
         mem_rd_data = 32'hA000 + 32'(j);
         #1;
         chk("rd_valid", 64'(s_rd_valid), 64'({mem_rd_data_valid, 1'b0}));
         chk("rd_data", 64'(s_rd_data), 64'(32'hA000 + 32'(j)));
         chk("rd_busy", 64'(busy), 64'(1));
         if (s_rd_valid[1]) cnt++;
      end
      chk("rd_beats", 64'(cnt), 64'(BL));
      for (int g = 0; g <= CG; g++) begin
         tick();
         mem_rd_data_valid = 1'b1;
         #1;
         chk("rd_gap_fwd", 64'(s_rd_valid), 64'(0));
         chk("rd_gap_busy", 64'(busy), 64'(g < CG));
      end
      mem_rd_data_valid = 1'b0;

      // arbitration: both ports write continuously from reset
      s_req_valid = 2'b11; s_req_we = 2'b11;
      do_reset();
      for (int c = 0; c < 300 && grants.size() < 4; c++) begin
         tick();
         #1;
         if (mem_cmd_en) begin
            grants.push_back(int'(s_wr_ready[1]));
            stamps.push_back(c);
         end
      end
      chk("arb_grant_count", 64'(grants.size()), 64'(4));
      for (int i = 0; i < grants.size(); i++)
         chk($sformatf("arb_grant%0d", i), 64'(grants[i]), 64'(i % 2));
      for (int i = 1; i < stamps.size(); i++)
         chk($sformatf("arb_spacing%0d", i), 64'(stamps[i] - stamps[i-1]), 64'(BL + CG + 1));
      s_req_valid = 2'b00;

      // read timeout after 5 beats
      do_reset();
      s_req_valid = 2'b01; s_req_we = 2'b00; s_req_addr0 = 22'h000055;
      #1;
      chk("tmo_accept_ready", 64'(s_req_ready), 64'(2'b01));
      tick();
      s_req_valid = 2'b00;
      for (int b = 0; b < 5; b++) begin
         tick();
         mem_rd_data_valid = 1'b1;
      end
      early = 0;
      for (int c = 1; c <= TO; c++) begin
         tick();
         mem_rd_data_valid = 1'b0;
         #1;
         if (err_timeout) early = 1;
      end
      chk("tmo_not_early", 64'(early), 64'(0));
      tick();
      #1;
      chk("tmo_err_rise", 64'(err_timeout), 64'(1));
      chk("tmo_gap_busy", 64'(busy), 64'(1));
      for (int g = 1; g < CG; g++) begin
         tick();
         #1;
         chk("tmo_gap_hold", 64'(busy), 64'(1));
      end
      tick();
      s_req_valid = 2'b10; s_req_we = 2'b10;
      #1;
      chk("tmo_idle", 64'(busy), 64'(0));
      chk("tmo_next_ready", 64'(s_req_ready), 64'(2'b10));
      tick();
      s_req_valid = 2'b00;
      #1;
      chk("tmo_next_cmd_en", 64'(mem_cmd_en), 64'(1));
      chk("tmo_err_sticky", 64'(err_timeout), 64'(1));

      // beat on the threshold cycle beats the timeout
      do_reset();
      #1;
      chk("bnd_err_cleared", 64'(err_timeout), 64'(0));
      s_req_valid = 2'b01; s_req_we = 2'b00;
      early = 0;
      for (int c = 1; c < TO; c++) begin
         tick();
         s_req_valid = 2'b00;
         #1;
         if (err_timeout) early = 1;
      end
      tick();
      mem_rd_data_valid = 1'b1;
      #1;
      chk("bnd_no_early", 64'(early), 64'(0));
      chk("bnd_beat_fwd", 64'(s_rd_valid), 64'(2'b01));
      for (int b = 1; b < BL; b++) begin
         tick();
         #1;
         chk("bnd_err_low", 64'(err_timeout), 64'(0));
      end
      tick();
      mem_rd_data_valid = 1'b0;
      #1;
      chk("bnd_done_err", 64'(err_timeout), 64'(0));
      chk("bnd_gap_busy", 64'(busy), 64'(1));
      chk("bnd_gap_fwd", 64'(s_rd_valid), 64'(0));

      // calibration gating and loss mid-write
      init_calib = 1'b0;
      s_req_valid = 2'b01; s_req_we = 2'b01;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         tick();
         #1;
         chk("cal_no_ready", 64'(s_req_ready), 64'(0));
         chk("cal_no_cmd", 64'(mem_cmd_en), 64'(0));
      end
      init_calib = 1'b1;
      #1;
      chk("cal_ready", 64'(s_req_ready), 64'(2'b01));
      s_wr_data0 = 32'h1234_5678;
      for (int k = 0; k < 7; k++) begin
         tick();
         s_req_valid = 2'b00;
         if (k == 6) init_calib = 1'b0;
         #1;
         chk("cal_wr_ready", 64'(s_wr_ready), 64'(2'b01));
      end
      tick();
      #1;
      chk("cal_lost_wr_ready", 64'(s_wr_ready), 64'(0));
      chk("cal_lost_busy", 64'(busy), 64'(0));
      chk("cal_lost_err", 64'(err_timeout), 64'(0));
      chk("cal_lost_wr_data", 64'(mem_wr_data), 64'(0));

      // reset during beat 8 of a read
      init_calib = 1'b1;
      do_reset();
      s_req_valid = 2'b10; s_req_we = 2'b00; s_req_addr1 = 22'h3FFFF0;
      tick();
      s_req_valid = 2'b00;
      #1;
      chk("rr_cmd_en", 64'(mem_cmd_en), 64'(1));
      for (int b = 1; b <= 8; b++) begin
         tick();
         mem_rd_data_valid = 1'b1;
         if (b == 8) reset = 1'b1;
         #1;
         chk("rr_beat_fwd", 64'(s_rd_valid), 64'(2'b10));
      end
      tick();
      #1;
      chk("rr_cmd_en_rst", 64'(mem_cmd_en), 64'(0));
      chk("rr_cmd_rst", 64'(mem_cmd), 64'(0));
      chk("rr_addr_rst", 64'(mem_addr), 64'(0));
      chk("rr_busy_rst", 64'(busy), 64'(0));
      chk("rr_err_rst", 64'(err_timeout), 64'(0));
      chk("rr_rd_valid_rst", 64'(s_rd_valid), 64'(0));
      chk("rr_wr_ready_rst", 64'(s_wr_ready), 64'(0));
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         #1;
         chk("rr_late_beat", 64'(s_rd_valid), 64'(0));
         chk("rr_late_busy", 64'(busy), 64'(0));
      end
      mem_rd_data_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
